// File: rtl/fifo_wr_rr_arbiter_if.sv
// Write-side bundle between NUM_REQ producers, the round-robin arbiter and one FIFO write port.
// The master modport is the arbiter's view; the slave modport is the producers/FIFO view.
interface fifo_wr_rr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_wr_en;
    logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_wr_data;
    logic                          fifo_wr_ready;
    logic                          grant_valid;
    logic [ID_WIDTH-1:0]           grant_id;

    modport master (
        input  req_valid, req_data, req_last, fifo_wr_ready,
        output req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id
    );

    modport slave (
        output req_valid, req_data, req_last, fifo_wr_ready,
        input  req_ready, fifo_wr_en, fifo_wr_data, grant_valid, grant_id
    );
endinterface

// File: rtl/fifo_wr_rr_arbiter.sv
// Round-robin owner-locked arbiter sharing one FIFO write port between NUM_REQ producers.
// A grant ends on the owner's last beat, after MAX_BURST beats, or after STALL_TIMEOUT idle cycles.
module fifo_wr_rr_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int MAX_BURST     = 8,
    parameter int STALL_TIMEOUT = 4,
    parameter int ID_WIDTH      = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    fifo_wr_rr_arbiter_if.master  bus
);
    localparam int BEAT_W  = $clog2(MAX_BURST + 1);
    localparam int STALL_W = $clog2(STALL_TIMEOUT + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t              state_q, state_d;
    logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
    logic [ID_WIDTH-1:0] last_owner_q, last_owner_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [ID_WIDTH-1:0]   winner;
    logic [ID_WIDTH-1:0]   cand;
    logic                  any_req;
    int unsigned           scan_idx;
    logic                  owner_valid;
    logic                  owner_last;
    logic [DATA_WIDTH-1:0] owner_data;
    logic                  beat;
    logic [NUM_REQ-1:0]    req_ready;

    // Scan starts just after the previous owner, so a released owner goes to the back of the line.
    always_comb begin
        winner   = '0;
        cand     = '0;
        any_req  = 1'b0;
        scan_idx = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            scan_idx = (32'(last_owner_q) + k) % NUM_REQ;
            cand     = ID_WIDTH'(scan_idx);
            if (!any_req && bus.req_valid[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

    always_comb begin
        owner_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_WIDTH'(i) == grant_id_q) owner_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign owner_valid = bus.req_valid[grant_id_q];
    assign owner_last  = bus.req_last[grant_id_q];

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        beat         = 1'b0;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d     = OWN;
                    grant_id_d  = winner;
                    beat_cnt_d  = '0;
                    stall_cnt_d = '0;
                end
            end
            OWN: begin
                beat = owner_valid & bus.fifo_wr_ready & ~reset;
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (ID_WIDTH'(i) == grant_id_q) req_ready[i] = bus.fifo_wr_ready & ~reset;
                end
                if (beat) begin
                    beat_cnt_d  = beat_cnt_q + BEAT_W'(1);
                    stall_cnt_d = '0;
                    if (owner_last || (int'(beat_cnt_q) + 1 == MAX_BURST)) begin
                        state_d      = IDLE;
                        last_owner_d = grant_id_q;
                    end
                end else if (!owner_valid) begin
                    // Only an idle owner ages the grant; a full FIFO holds it indefinitely.
                    stall_cnt_d = stall_cnt_q + STALL_W'(1);
                    if (int'(stall_cnt_q) + 1 == STALL_TIMEOUT) begin
                        state_d      = IDLE;
                        last_owner_d = grant_id_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            last_owner_q <= ID_WIDTH'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.fifo_wr_en   = beat;
    assign bus.fifo_wr_data = {grant_id_q, owner_data};
    assign bus.grant_valid  = (state_q == OWN);
    assign bus.grant_id     = grant_id_q;
endmodule

// File: tb/tb_fifo_wr_rr_arbiter.sv
// Bench for fifo_wr_rr_arbiter: queued producers, a cycle-level behavioural model and a write log.
module tb_fifo_wr_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 8;
    localparam int ST = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_wr_rr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus();

    fifo_wr_rr_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .STALL_TIMEOUT(ST)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Producer queues: {last, data} per entry, popped on each accepted handshake.
    logic [DW:0] mem [N][64];
    int head [N];
    int tail [N];

    task automatic push(input int r, input logic [DW-1:0] d, input logic l);
        mem[r][tail[r]] = {l, d};
        tail[r]++;
    endtask

    initial begin
        logic [N-1:0] fire;
        for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        forever begin
            @(negedge clk);
            fire = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (fire[i]) head[i]++;
                if (head[i] < tail[i]) begin
                    bus.req_valid[i]         = 1'b1;
                    bus.req_data[i*DW +: DW] = mem[i][head[i]][DW-1:0];
                    bus.req_last[i]          = mem[i][head[i]][DW];
                end else begin
                    bus.req_valid[i]         = 1'b0;
                    bus.req_data[i*DW +: DW] = '0;
                    bus.req_last[i]          = 1'b0;
                end
            end
        end
    end

    // Model: who owns the port, how many beats and idle cycles this grant has seen.
    int cyc = 0;
    logic [IW+DW-1:0] wlog [$];
    int wcyc [$];
    bit m_own;
    int m_id, m_last, m_beats, m_stall;

    initial begin
        bit e_en;
        int e_rdy;
        bit picked;
        m_own = 0; m_id = 0; m_last = N - 1; m_beats = 0; m_stall = 0;
        forever begin
            @(negedge clk);
            cyc++;
            e_en  = !reset && m_own && bus.req_valid[m_id] && bus.fifo_wr_ready;
            e_rdy = (!reset && m_own && bus.fifo_wr_ready) ? (1 << m_id) : 0;
            check("grant_valid", 32'(bus.grant_valid), 32'(m_own));
            check("grant_id", 32'(bus.grant_id), m_id);
            check("req_ready", 32'(bus.req_ready), e_rdy);
            check("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(e_en));
            if (e_en)
                check("fifo_wr_data", 32'(bus.fifo_wr_data),
                      32'({m_id[IW-1:0], bus.req_data[m_id*DW +: DW]}));
            if (bus.fifo_wr_en === 1'b1) begin
                wlog.push_back(bus.fifo_wr_data);
                wcyc.push_back(cyc);
            end
            if (reset) begin
                m_own = 0; m_id = 0; m_last = N - 1; m_beats = 0; m_stall = 0;
            end else if (!m_own) begin
                picked = 0;
                for (int k = 1; k <= N; k++) begin
                    if (!picked && bus.req_valid[(m_last + k) % N]) begin
                        picked = 1;
                        m_id   = (m_last + k) % N;
                    end
                end
                if (picked) begin m_own = 1; m_beats = 0; m_stall = 0; end
            end else if (e_en) begin
                m_beats++;
                m_stall = 0;
                if (bus.req_last[m_id] || m_beats == MB) begin m_own = 0; m_last = m_id; end
            end else if (!bus.req_valid[m_id]) begin
                m_stall++;
                if (m_stall == ST) begin m_own = 0; m_last = m_id; end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        bus.fifo_wr_ready = 1'b1;
        for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
        wlog.delete();
        wcyc.delete();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int t = 0;
        while (wlog.size() < n && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        check(name, wlog.size(), n);
    endtask

    initial begin
        int j;
        reset = 1'b1;
        bus.fifo_wr_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_grant_valid", 32'(bus.grant_valid), 0);
        check("reset_grant_id", 32'(bus.grant_id), 0);
        check("reset_wr_en", 32'(bus.fifo_wr_en), 0);

        // Single requester, 3-beat packet
        do_reset();
        push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b1);
        wait_writes(3, 50, "t1_count");
        check("t1_w0", 32'(wlog[0]), 32'h0A0);
        check("t1_w1", 32'(wlog[1]), 32'h0A1);
        check("t1_w2", 32'(wlog[2]), 32'h0A2);
        check("t1_gap0", wcyc[1] - wcyc[0], 1);
        check("t1_gap1", wcyc[2] - wcyc[1], 1);
        repeat (2) @(negedge clk);
        check("t1_released", 32'(bus.grant_valid), 0);

        // Fairness with 1-beat packets
        do_reset();
        for (int rep = 0; rep < 2; rep++)
            for (int r = 0; r < N; r++) push(r, 8'(16 * r + rep), 1'b1);
        wait_writes(8, 100, "t2_count");
        for (int i = 0; i < 8; i++) check("t2_order", 32'(wlog[i][DW +: IW]), i % N);
        for (int i = 0; i < 7; i++) check("t2_spacing", wcyc[i+1] - wcyc[i], 2);

        // Burst limit splits requester 2's long packet
        do_reset();
        for (int i = 0; i < 20; i++) push(2, 8'(8'h20 + i), 1'b0);
        repeat (2) @(negedge clk);
        push(1, 8'hB0, 1'b0); push(1, 8'hB1, 1'b1);
        wait_writes(22, 300, "t3_count");
        for (int i = 0; i < 22; i++)
            check("t3_owner", 32'(wlog[i][DW +: IW]), (i == 8 || i == 9) ? 1 : 2);
        j = 0;
        for (int i = 0; i < 22; i++)
            if (wlog[i][DW +: IW] == 2'd2) begin
                check("t3_data", 32'(wlog[i][DW-1:0]), 32'h20 + j);
                j++;
            end
        check("t3_bubble", wcyc[8] - wcyc[7], 2);

        // Stall timeout hands the port to a waiting requester
        do_reset();
        push(1, 8'hC0, 1'b0); push(1, 8'hC1, 1'b0); push(3, 8'hD0, 1'b1);
        wait_writes(3, 100, "t4_count");
        check("t4_w0", 32'(wlog[0]), 32'h1C0);
        check("t4_w1", 32'(wlog[1]), 32'h1C1);
        check("t4_w2", 32'(wlog[2]), 32'h3D0);
        check("t4_gap", wcyc[2] - wcyc[1], 6);

        // Backpressure holds the grant without losing beats
        do_reset();
        for (int i = 0; i < 5; i++) push(0, 8'(8'hE0 + i), i == 4);
        wait_writes(2, 50, "t5_pre");
        @(posedge clk);
        #2 bus.fifo_wr_ready = 1'b0;
        repeat (10) @(posedge clk);
        #2 bus.fifo_wr_ready = 1'b1;
        wait_writes(5, 50, "t5_count");
        for (int i = 0; i < 5; i++) check("t5_data", 32'(wlog[i]), 32'h0E0 + i);
        check("t5_gap", wcyc[2] - wcyc[1], 11);

        // Reset on beat 2 of 5 drops that beat; requester 0 re-sends and wins first
        do_reset();
        for (int i = 0; i < 5; i++) push(0, 8'(8'hF0 + i), i == 4);
        wait_writes(1, 50, "t6_pre");
        @(posedge clk);
        #2 reset = 1'b1;
        push(2, 8'h90, 1'b1);
        @(negedge clk);
        check("t6_rst_wr_en", 32'(bus.fifo_wr_en), 0);
        check("t6_rst_req_ready", 32'(bus.req_ready), 0);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("t6_grant_cleared", 32'(bus.grant_valid), 0);
        wait_writes(6, 100, "t6_count");
        check("t6_w1", 32'(wlog[1]), 32'h0F1);
        check("t6_w4", 32'(wlog[4]), 32'h0F4);
        check("t6_w5", 32'(wlog[5]), 32'h290);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
